// File: rtl/mac3_pkg.sv
// rtl/mac3_pkg.sv - shared types, constants and the saturate/truncate helper for mac3_stream
package mac3_pkg;

    typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} mac_op_e;

    localparam int RUN_LEN = 3;
    localparam int MAX_DW  = 32;
    localparam int MAX_RW  = 2*MAX_DW + 2;
    localparam int MAX_OW  = 2*MAX_DW + 1;

    // Returns {ovf, value}; value is right-aligned, only the low ow bits are meaningful.
    function automatic logic [MAX_OW:0] sat_trunc(
        input logic signed [MAX_RW-1:0] r,
        input int                       ow,
        input bit                       sat
    );
        logic signed [MAX_RW-1:0] top;
        logic        [MAX_OW-1:0] low;
        top = (MAX_RW'(1) << ow) - MAX_RW'(1);
        low = MAX_OW'(r & top);
        if (r < 0)
            sat_trunc = {1'b1, sat ? {MAX_OW{1'b0}} : low};
        else if (r > top)
            sat_trunc = {1'b1, sat ? MAX_OW'(top) : low};
        else
            sat_trunc = {1'b0, MAX_OW'(r)};
    endfunction

endpackage

// File: rtl/mac3_arith.sv
// rtl/mac3_arith.sv - combinational multiplier and add/sub/saturate halves of the mac3 datapath
module mac3_arith
    import mac3_pkg::*;
#(
    parameter int DW  = 32,
    parameter int OW  = 32,
    parameter int SAT = 1
) (
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [2*DW-1:0] prod,
    input  logic [2*DW-1:0] prod_in,
    input  logic [DW-1:0]   c,
    input  mac_op_e         op,
    output logic [OW-1:0]   result,
    output logic            ovf
);

    localparam int RW = 2*DW + 2;

    logic signed [RW-1:0] r;
    logic [MAX_OW:0]      st;

    // The two halves are separate so the top can place a register between them.
    assign prod = a * b;

    always_comb begin
        if (op == OP_SUB)
            r = $signed({2'b00, prod_in}) - $signed({{(DW+2){1'b0}}, c});
        else
            r = $signed({2'b00, prod_in}) + $signed({{(DW+2){1'b0}}, c});
        st = sat_trunc(MAX_RW'(r), OW, SAT != 0);
    end

    assign result = OW'(st[MAX_OW-1:0]);
    assign ovf    = st[MAX_OW];

endmodule

// File: rtl/mac3_stream.sv
// rtl/mac3_stream.sv - sliding three-sample a*b+/-c unit; MAC3_STREAM_PIPE_EN adds a multiplier pipe stage
module mac3_stream
    import mac3_pkg::*;
#(
    parameter int DW  = 32,
    parameter int OW  = 32,
    parameter int SAT = 1
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          validi,
    input  logic [DW-1:0] data_in,
    input  logic          sub_i,
    output logic          valido,
    output logic [OW-1:0] data_out,
    output logic          ovf,
    output logic [1:0]    run_cnt
);

    logic [DW-1:0]   a_q;
    logic [DW-1:0]   b_q;
    logic            win;
    logic [2*DW-1:0] prod;
    logic [2*DW-1:0] prod_s;
    logic [DW-1:0]   c_s;
    mac_op_e         op_s;
    logic            win_s;
    logic [OW-1:0]   res;
    logic            res_ovf;

    assign win = validi && (run_cnt >= 2'(RUN_LEN - 1));

    always_ff @(posedge clk) begin
        if (!rst_) begin
            run_cnt <= 2'd0;
            a_q     <= '0;
            b_q     <= '0;
        end else if (validi) begin
            a_q <= b_q;
            b_q <= data_in;
            if (run_cnt != 2'(RUN_LEN))
                run_cnt <= run_cnt + 2'd1;
        end else begin
            run_cnt <= 2'd0;
        end
    end

`ifdef MAC3_STREAM_PIPE_EN
    logic [2*DW-1:0] prod_q;
    logic [DW-1:0]   c_q;
    mac_op_e         op_q;
    logic            win_q;

    always_ff @(posedge clk) begin
        if (!rst_) begin
            win_q  <= 1'b0;
            prod_q <= '0;
            c_q    <= '0;
            op_q   <= OP_ADD;
        end else begin
            win_q <= win;
            if (win) begin
                prod_q <= prod;
                c_q    <= data_in;
                op_q   <= mac_op_e'(sub_i);
            end
        end
    end

    assign prod_s = prod_q;
    assign c_s    = c_q;
    assign op_s   = op_q;
    assign win_s  = win_q;
`else
    assign prod_s = prod;
    assign c_s    = data_in;
    assign op_s   = mac_op_e'(sub_i);
    assign win_s  = win;
`endif

    mac3_arith #(
        .DW  (DW),
        .OW  (OW),
        .SAT (SAT)
    ) u_arith (
        .a       (a_q),
        .b       (b_q),
        .prod    (prod),
        .prod_in (prod_s),
        .c       (c_s),
        .op      (op_s),
        .result  (res),
        .ovf     (res_ovf)
    );

    // data_out and ovf hold between results; only valido pulses.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            valido   <= 1'b0;
            data_out <= '0;
            ovf      <= 1'b0;
        end else begin
            valido <= win_s;
            if (win_s) begin
                data_out <= res;
                ovf      <= res_ovf;
            end
        end
    end

endmodule

// File: tb/tb_mac3_stream.sv
// tb/tb_mac3_stream.sv - scoreboard bench for mac3_stream, saturating and wrapping instances side by side
module tb_mac3_stream;

    logic        clk     = 1'b0;
    logic        rst_    = 1'b0;
    logic        validi  = 1'b0;
    logic        sub_i   = 1'b0;
    logic [31:0] data_in = '0;

    logic        valido1, ovf1, valido0, ovf0;
    logic [31:0] dout1, dout0;
    logic [1:0]  rc1, rc0;

`ifdef MAC3_STREAM_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int          due;
        logic [31:0] d1;
        logic        o1;
        logic [31:0] d0;
        logic        o0;
    } exp_t;

    exp_t        sb[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          cyc        = 0;
    int          exp_cnt    = 0;
    int          m_cnt      = 0;
    logic [31:0] ma = '0, mb = '0;
    logic [31:0] last1 = '0, last0 = '0;
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mac3_stream #(.DW(32), .OW(32), .SAT(1)) dut_sat (
        .clk(clk), .rst_(rst_), .validi(validi), .data_in(data_in), .sub_i(sub_i),
        .valido(valido1), .data_out(dout1), .ovf(ovf1), .run_cnt(rc1)
    );

    mac3_stream #(.DW(32), .OW(32), .SAT(0)) dut_wrap (
        .clk(clk), .rst_(rst_), .validi(validi), .data_in(data_in), .sub_i(sub_i),
        .valido(valido0), .data_out(dout0), .ovf(ovf0), .run_cnt(rc0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic s);
        exp_t        e;
        logic [63:0] p;
        logic [64:0] r;
        bit          neg;
        p   = 64'(a) * 64'(b);
        neg = s && (64'(c) > p);
        r   = s ? (65'(p) - 65'(c)) : (65'(p) + 65'(c));
        e.due = cyc + LAT;
        if (neg) begin
            e.d1 = 32'd0;    e.o1 = 1'b1;
            e.d0 = r[31:0];  e.o0 = 1'b1;
        end else if (r > 65'h0_FFFF_FFFF) begin
            e.d1 = 32'hFFFF_FFFF; e.o1 = 1'b1;
            e.d0 = r[31:0];       e.o0 = 1'b1;
        end else begin
            e.d1 = r[31:0]; e.o1 = 1'b0;
            e.d0 = r[31:0]; e.o0 = 1'b0;
        end
        sb.push_back(e);
    endfunction

    task automatic step(input logic r, input logic v, input logic [31:0] d, input logic s);
        int nc;
        rst_ = r; validi = v; data_in = d; sub_i = s;
        if (!r) begin
            nc = 0; ma = '0; mb = '0;
        end else if (v) begin
            if (m_cnt >= 2) push(ma, mb, d, s);
            ma = mb; mb = d;
            nc = (m_cnt < 3) ? m_cnt + 1 : 3;
        end else begin
            nc = 0;
        end
        m_cnt = nc;
        @(posedge clk); #1;
        exp_cnt = nc;
        if (!r) begin last1 = '0; last0 = '0; end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            bit   ev;
            ev = (sb.size() > 0) && (sb[0].due == cyc);
            chk("run_cnt_sat", 64'(rc1), 64'(exp_cnt));
            chk("run_cnt_wrap", 64'(rc0), 64'(exp_cnt));
            chk("valido_sat", 64'(valido1), 64'(ev));
            chk("valido_wrap", 64'(valido0), 64'(ev));
            if (ev) begin
                e = sb.pop_front();
                chk("data_sat", 64'(dout1), 64'(e.d1));
                chk("ovf_sat", 64'(ovf1), 64'(e.o1));
                chk("data_wrap", 64'(dout0), 64'(e.d0));
                chk("ovf_wrap", 64'(ovf0), 64'(e.o0));
                last1 = e.d1;
                last0 = e.d0;
            end else begin
                chk("hold_sat", 64'(dout1), 64'(last1));
                chk("hold_wrap", 64'(dout0), 64'(last0));
            end
        end
    end

    initial begin
        // reset dominates validi
        step(1'b0, 1'b1, 32'd7, 1'b0);
        mon_en = 1'b1;
        step(1'b0, 1'b1, 32'd7, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);

        // basic add, then hold
        step(1'b1, 1'b1, 32'd2, 1'b0);
        step(1'b1, 1'b1, 32'd3, 1'b0);
        step(1'b1, 1'b1, 32'd4, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);

        // gap breaks the window
        step(1'b1, 1'b1, 32'd9, 1'b0);
        step(1'b1, 1'b1, 32'd8, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 32'd6, 1'b0);
        step(1'b1, 1'b1, 32'd5, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);

        // sliding: 10 then 17
        step(1'b1, 1'b1, 32'd2, 1'b0);
        step(1'b1, 1'b1, 32'd3, 1'b0);
        step(1'b1, 1'b1, 32'd4, 1'b0);
        step(1'b1, 1'b1, 32'd5, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);

        // sub underflow: 0 / 0xFFFFFFFC
        step(1'b1, 1'b1, 32'd2, 1'b0);
        step(1'b1, 1'b1, 32'd3, 1'b0);
        step(1'b1, 1'b1, 32'd10, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);

        // overflow: 0xFFFFFFFF / 1
        step(1'b1, 1'b1, 32'h1_0000, 1'b0);
        step(1'b1, 1'b1, 32'h1_0000, 1'b0);
        step(1'b1, 1'b1, 32'd1, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);

        // exact fit: 0xFFFF*0xFFFF + 0x1FFFE = 0xFFFFFFFF, no overflow
        step(1'b1, 1'b1, 32'hFFFF, 1'b0);
        step(1'b1, 1'b1, 32'hFFFF, 1'b0);
        step(1'b1, 1'b1, 32'h1_FFFE, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);

        // reset mid-run: old samples never contribute
        step(1'b1, 1'b1, 32'd5, 1'b0);
        step(1'b1, 1'b1, 32'd6, 1'b0);
        step(1'b0, 1'b1, 32'd7, 1'b0);
        step(1'b1, 1'b1, 32'd1, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 32'd1, 1'b0);
        step(1'b1, 1'b1, 32'd2, 1'b0);
        step(1'b1, 1'b1, 32'd3, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);

        // random sliding run with mixed ops
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b1, $urandom, 1'($urandom_range(1, 0)));
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 32'd0, 1'b0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
